// File: rtl/pixel_fifo_pkg.sv
// Shared types and helpers for the PPU pixel row FIFO.
// Entry colour lives in the low PIXEL_COLOR_W bits; colour 0 means transparent.
package pixel_fifo_pkg;

  localparam int PIXEL_COLOR_W = 2;
  localparam logic [PIXEL_COLOR_W-1:0] COLOR_TRANSPARENT = 2'b00;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_MERGE,
    ACT_DISCARD,
    ACT_POP
  } fifo_action_e;

  function automatic logic is_transparent(input logic [PIXEL_COLOR_W-1:0] colour);
    return colour == COLOR_TRANSPARENT;
  endfunction

endpackage

// File: rtl/pixel_merge_lane.sv
// One slot of the sprite-row merge: keeps the stored entry unless it is transparent
// (or the slot is empty). Only compiled when PIXEL_FIFO_MERGE_EN is defined.
`ifdef PIXEL_FIFO_MERGE_EN
module pixel_merge_lane
  import pixel_fifo_pkg::*;
#(
  parameter int PIXEL_W = 5
) (
  input  logic [PIXEL_W-1:0] stored_in,
  input  logic [PIXEL_W-1:0] merge_in,
  input  logic               occupied_in,
  output logic [PIXEL_W-1:0] slot_out
);

  always_comb begin
    slot_out = stored_in;
    if (!occupied_in ||
        (is_transparent(stored_in[PIXEL_COLOR_W-1:0]) &&
         !is_transparent(merge_in[PIXEL_COLOR_W-1:0])))
      slot_out = merge_in;
  end

endmodule
`endif

// File: rtl/pixel_row_fifo.sv
// Row-push / pixel-pop FIFO for the PPU pipeline with head discard and clear.
// Define PIXEL_FIFO_MERGE_EN to add sprite-row merge into the head entries.
module pixel_row_fifo
  import pixel_fifo_pkg::*;
#(
  parameter int PIXEL_W    = 5,
  parameter int ROW_PIXELS = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          tclk_in,
  input  logic                          push_valid_in,
  output logic                          push_ready_out,
  input  logic [ROW_PIXELS*PIXEL_W-1:0] push_row_in,
  input  logic                          pop_en_in,
  output logic [PIXEL_W-1:0]            pixel_out,
  output logic                          pixel_valid_out,
  input  logic                          discard_valid_in,
  input  logic [$clog2(ROW_PIXELS)-1:0] discard_cnt_in,
  input  logic                          clear_in,
  input  logic                          merge_valid_in,
  input  logic [ROW_PIXELS*PIXEL_W-1:0] merge_row_in,
  output logic [$clog2(DEPTH):0]        occupancy_out,
  output logic                          empty_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
  localparam logic [OW-1:0] ROW_O   = OW'(ROW_PIXELS);

  logic [PIXEL_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic               valid_q, valid_d;
  logic [OW-1:0]      disc_amt, merge_occ;
  logic               merge_req, push_fire;
  fifo_action_e       action;

`ifdef PIXEL_FIFO_MERGE_EN
  logic [PIXEL_W-1:0] merge_slot [ROW_PIXELS];

  assign merge_req = merge_valid_in;

  for (genvar gi = 0; gi < ROW_PIXELS; gi++) begin : g_lane
    pixel_merge_lane #(.PIXEL_W(PIXEL_W)) u_lane (
      .stored_in  (mem_q[rd_ptr_q + AW'(gi)]),
      .merge_in   (merge_row_in[gi*PIXEL_W +: PIXEL_W]),
      .occupied_in(occ_q > OW'(gi)),
      .slot_out   (merge_slot[gi])
    );
  end
`else
  logic unused_merge;
  assign merge_req    = 1'b0;
  assign unused_merge = ^{merge_valid_in, merge_row_in};
`endif

  assign push_ready_out = rst_in && !merge_req && (DEPTH_O - occ_q >= ROW_O);

  // Only one head action per T-cycle: clear > merge > discard > pop.
  always_comb begin
    action = ACT_NONE;
    if (tclk_in && rst_in) begin
      if (clear_in)                          action = ACT_CLEAR;
      else if (merge_req)                    action = ACT_MERGE;
      else if (discard_valid_in)             action = ACT_DISCARD;
      else if (pop_en_in && occ_q != '0)     action = ACT_POP;
    end
  end

  assign push_fire = tclk_in && push_valid_in && push_ready_out && (action != ACT_CLEAR);
  assign disc_amt  = (OW'(discard_cnt_in) < occ_q) ? OW'(discard_cnt_in) : occ_q;
  assign merge_occ = (occ_q > ROW_O) ? occ_q : ROW_O;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    pixel_d  = pixel_q;
    valid_d  = 1'b0;
    case (action)
      ACT_CLEAR: begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        occ_d    = '0;
      end
      ACT_MERGE: begin
        occ_d    = merge_occ;
        wr_ptr_d = rd_ptr_q + AW'(merge_occ);
      end
      ACT_DISCARD: begin
        rd_ptr_d = rd_ptr_q + AW'(disc_amt);
        occ_d    = occ_q - disc_amt;
      end
      ACT_POP: begin
        pixel_d  = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
        rd_ptr_d = rd_ptr_q + AW'(1);
        occ_d    = occ_q - OW'(1);
      end
      default: ;
    endcase
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + AW'(ROW_PIXELS);
      occ_d    = occ_d + ROW_O;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      pixel_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      pixel_q  <= pixel_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is never reset; push and merge are mutually exclusive in a cycle.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < ROW_PIXELS; i++) begin
      if (push_fire)
        mem_q[wr_ptr_q + AW'(i)] <= push_row_in[i*PIXEL_W +: PIXEL_W];
`ifdef PIXEL_FIFO_MERGE_EN
      if (action == ACT_MERGE)
        mem_q[rd_ptr_q + AW'(i)] <= merge_slot[i];
`endif
    end
  end

  assign pixel_out       = pixel_q;
  assign pixel_valid_out = valid_q;
  assign occupancy_out   = occ_q;
  assign empty_out       = (occ_q == '0);

endmodule

// File: tb/tb_pixel_row_fifo.sv
// Directed bench for pixel_row_fifo: queue-based reference model checked every cycle,
// plus literal expectations per test. Define PIXEL_FIFO_MERGE_EN to run the merge test.
module tb_pixel_row_fifo;

  logic        clk = 1'b0;
  logic        rst_in, tclk_in, push_valid_in, pop_en_in, discard_valid_in, clear_in, merge_valid_in;
  logic [39:0] push_row_in, merge_row_in;
  logic [2:0]  discard_cnt_in;
  logic        push_ready_out, pixel_valid_out, empty_out;
  logic [4:0]  pixel_out;
  logic [4:0]  occupancy_out;

  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  logic last_valid;

  logic [4:0] mq[$];
  logic       exp_valid = 1'b0;
  logic [4:0] exp_pix = '0;
  logic       exp_ready;
  logic [4:0] mrg;
  int         n;
  bit         room;

  always #5 clk = ~clk;

  pixel_row_fifo #(.PIXEL_W(5), .ROW_PIXELS(8), .DEPTH(16)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .tclk_in         (tclk_in),
    .push_valid_in   (push_valid_in),
    .push_ready_out  (push_ready_out),
    .push_row_in     (push_row_in),
    .pop_en_in       (pop_en_in),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .discard_valid_in(discard_valid_in),
    .discard_cnt_in  (discard_cnt_in),
    .clear_in        (clear_in),
    .merge_valid_in  (merge_valid_in),
    .merge_row_in    (merge_row_in),
    .occupancy_out   (occupancy_out),
    .empty_out       (empty_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue of entries, updated on each T-cycle.
  always @(posedge clk) begin
    exp_valid = 1'b0;
    if (!rst_in) begin
      mq.delete();
      exp_pix = '0;
    end else if (tclk_in) begin
      if (clear_in) mq.delete();
`ifdef PIXEL_FIFO_MERGE_EN
      else if (merge_valid_in) begin
        for (int i = 0; i < 8; i++) begin
          mrg = merge_row_in[i*5 +: 5];
          if (i < mq.size()) begin
            if (mq[i][1:0] == 2'd0 && mrg[1:0] != 2'd0) mq[i] = mrg;
          end else mq.push_back(mrg);
        end
      end
`endif
      else begin
        room = (mq.size() <= 8);
        if (discard_valid_in) begin
          n = int'(discard_cnt_in);
          if (n > mq.size()) n = mq.size();
          repeat (n) void'(mq.pop_front());
        end else if (pop_en_in && mq.size() > 0) begin
          exp_pix   = mq.pop_front();
          exp_valid = 1'b1;
        end
        if (push_valid_in && room)
          for (int i = 0; i < 8; i++) mq.push_back(push_row_in[i*5 +: 5]);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_ready = rst_in && (mq.size() <= 8);
`ifdef PIXEL_FIFO_MERGE_EN
      if (merge_valid_in) exp_ready = 1'b0;
`endif
      chk("model_occupancy", occupancy_out, mq.size());
      chk("model_empty", empty_out, mq.size() == 0);
      chk("model_push_ready", push_ready_out, exp_ready);
      chk("model_pixel_valid", pixel_valid_out, exp_valid);
      chk("model_pixel", pixel_out, exp_pix);
    end
  end

  function automatic logic [39:0] seq_row(input int base);
    logic [39:0] r;
    for (int i = 0; i < 8; i++) r[i*5 +: 5] = 5'(base + i);
    return r;
  endfunction

  task automatic idle_inputs();
    push_valid_in = 0; pop_en_in = 0; discard_valid_in = 0; discard_cnt_in = 0;
    clear_in = 0; merge_valid_in = 0; push_row_in = '0; merge_row_in = '0;
  endtask

  // One T-cycle with the staged inputs, then one non-T cycle with random noise.
  task automatic go();
    tclk_in = 1'b1;
    @(posedge clk); #2;
    last_valid = pixel_valid_out;
    tclk_in = 1'b0;
    push_valid_in = 1'($urandom); pop_en_in = 1'($urandom);
    discard_valid_in = 1'($urandom); discard_cnt_in = 3'($urandom);
    clear_in = 1'($urandom); merge_valid_in = 1'($urandom);
    push_row_in = {$urandom, 8'($urandom)}; merge_row_in = {$urandom, 8'($urandom)};
    @(posedge clk); #2;
    idle_inputs();
  endtask

  initial begin
    rst_in = 1'b0; tclk_in = 1'b0;
    idle_inputs();
    // T1 reset
    repeat (2) @(posedge clk);
    #2;
    chk("t1_occupancy", occupancy_out, 0);
    chk("t1_empty", empty_out, 1);
    chk("t1_push_ready", push_ready_out, 0);
    chk("t1_pixel_valid", pixel_valid_out, 0);
    cmp_en = 1'b1;
    rst_in = 1'b1;
    #1 chk("t1_ready_after_reset", push_ready_out, 1);

    // T2 push with pop into empty FIFO (no fall-through), then 8 pops
    push_row_in = seq_row(0); push_valid_in = 1; pop_en_in = 1; go();
    chk("t2_occ_after_push", occupancy_out, 8);
    chk("t2_no_fallthrough", last_valid, 0);
    for (int i = 0; i < 8; i++) begin
      pop_en_in = 1; go();
      chk("t2_pop_pixel", pixel_out, i);
      chk("t2_pop_valid", last_valid, 1);
    end
    chk("t2_empty", empty_out, 1);

    // T3 full FIFO, held push, pop+push wrap
    push_row_in = seq_row(8); push_valid_in = 1; go();
    push_row_in = seq_row(16); push_valid_in = 1; go();
    chk("t3_occ_full", occupancy_out, 16);
    chk("t3_ready_full", push_ready_out, 0);
    push_row_in = seq_row(24); push_valid_in = 1; go();
    chk("t3_push_held", occupancy_out, 16);
    for (int i = 0; i < 8; i++) begin
      pop_en_in = 1; go();
      chk("t3_pop_pixel", pixel_out, 8 + i);
    end
    push_row_in = seq_row(24); push_valid_in = 1; pop_en_in = 1; go();
    chk("t3_occ_pop_push", occupancy_out, 15);
    chk("t3_pixel_pop_push", pixel_out, 16);
    for (int i = 0; i < 15; i++) begin
      pop_en_in = 1; go();
      chk("t3_wrap_pixel", pixel_out, 17 + i);
    end
    chk("t3_empty", empty_out, 1);

    // T4 discard
    push_row_in = seq_row(0); push_valid_in = 1; go();
    discard_valid_in = 1; discard_cnt_in = 3; pop_en_in = 1; go();
    chk("t4_occ_discard3", occupancy_out, 5);
    chk("t4_discard_no_pop", last_valid, 0);
    pop_en_in = 1; go();
    chk("t4_pixel_after_discard", pixel_out, 3);
    clear_in = 1; go();
    push_row_in = seq_row(0); push_valid_in = 1; go();
    discard_valid_in = 1; discard_cnt_in = 3; go();
    chk("t4_occ_discard3b", occupancy_out, 5);
    discard_valid_in = 1; discard_cnt_in = 7; go();
    chk("t4_discard_saturate", occupancy_out, 0);

    // T5 clear beats push and pop
    push_row_in = seq_row(0); push_valid_in = 1; go();
    push_row_in = seq_row(8); push_valid_in = 1; go();
    for (int i = 0; i < 4; i++) begin
      pop_en_in = 1; go();
    end
    chk("t5_occ_12", occupancy_out, 12);
    clear_in = 1; push_row_in = seq_row(16); push_valid_in = 1; pop_en_in = 1; go();
    chk("t5_occ_cleared", occupancy_out, 0);
    chk("t5_no_pop", last_valid, 0);
    chk("t5_pixel_held", pixel_out, 3);

`ifdef PIXEL_FIFO_MERGE_EN
    // T6 merge: head colours 0,2,0 merged with 1,1,1,3,0,0,0,0
    begin
      int          cols[8] = '{1, 1, 1, 1, 1, 0, 2, 0};
      int          mcol[8] = '{1, 1, 1, 3, 0, 0, 0, 0};
      int          expv[8] = '{29, 26, 29, 31, 28, 28, 28, 28};
      logic [39:0] r, m;
      for (int i = 0; i < 8; i++) begin
        r[i*5 +: 5] = 5'(i * 4 + cols[i]);
        m[i*5 +: 5] = 5'(28 + mcol[i]);
      end
      push_row_in = r; push_valid_in = 1; go();
      discard_valid_in = 1; discard_cnt_in = 5; go();
      chk("t6_occ_3", occupancy_out, 3);
      merge_row_in = m; merge_valid_in = 1; push_row_in = r; push_valid_in = 1; pop_en_in = 1;
      #1 chk("t6_ready_blocked", push_ready_out, 0);
      go();
      chk("t6_occ_merged", occupancy_out, 8);
      chk("t6_merge_no_pop", last_valid, 0);
      for (int i = 0; i < 8; i++) begin
        pop_en_in = 1; go();
        chk("t6_merged_pixel", pixel_out, expv[i]);
      end
    end
`endif

    repeat (3) @(posedge clk);
    #2;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
